op_seq_issuer: RTL and testbench
================================

// Module: op_seq_issuer
// PURPOSE
//  Initiator for the 2-bit op/dest register-datapath interface: drives op[1:0]/dest each cycle from a
//  small loadable program instead of a bench. Program words are written over a simple write port;
//  a start pulse runs the program, each word repeated rep+1 cycles, until HALT or the last address.
//  Sits between the lab top level and the register datapath that holds R0/R1.
// PARAMETERS
//  DEPTH   8  program words (power of 2, >=2); AW = $clog2(DEPTH)
//  REP_W   2  width of per-word repeat field; word issued rep+1 cycles (1..2**REP_W)
// PORTS
//  clk      in   1       rising-edge clock, sole clock domain
//  reset    in   1       asynchronous, active-high reset
//  wr_en    in   1       program write strobe; honoured only when busy=0
//  wr_addr  in   AW      program word address
//  wr_data  in   REP_W+3 word {op[1:0], dest, rep[REP_W-1:0]}
//  start    in   1       run request, sampled in IDLE only
//  hold     in   1       stall: freeze pc/count and issue NOP this cycle
//  op       out  2       datapath opcode (00 = NOP)
//  dest     out  1       datapath destination select (0=R0, 1=R1)
//  busy     out  1       1 while in RUN
//  done     out  1       one-cycle pulse when program ends
//  pc       out  AW      current program address (debug)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=0, cnt=0, op=00, dest=0, busy=0, done=0; every memory
//   word cleared to HALT. Reset mid-RUN aborts with no further ops issued.
//  HALT word: op=00, dest=1 (rep ignored). op=00, dest=0 is a plain NOP issued rep+1 cycles.
//  States: IDLE -> RUN on start; RUN -> DONE at program end; DONE -> IDLE unconditionally (1 cycle).
//  IDLE/DONE: op=00, dest=0. done=1 only in DONE. start in RUN/DONE ignored.
//  Writes: registered on the edge; wr_en in RUN ignored (memory unchanged). wr_en+start in the same
//   IDLE cycle: write lands, run starts; first fetch sees the new word.
//  Start latency: start sampled at edge N -> RUN, pc=0, cnt=0; op/dest of word 0 valid in cycle
//   after edge N, consumed by datapath at edge N+1.
//  RUN, op/dest combinational from mem[pc] and state. If hold=1: op=00, dest=0, pc/cnt frozen.
//  RUN, hold=0, word=HALT: op=00, at edge -> DONE (HALT costs one NOP cycle).
//  RUN, hold=0, other word: issue op/dest; if cnt==rep: cnt<=0, and pc==DEPTH-1 ? DONE : pc<=pc+1;
//   else cnt<=cnt+1. pc never wraps without OP_SEQ_LOOP_EN.
//  Repeat count compare is unsigned REP_W bits; rep=all-ones gives 2**REP_W issues.
// CONFIGURATION
//  OP_SEQ_LOOP_EN defined: adds input port loop (1 bit). At program end (HALT executed or last word
//   finished) with loop=1: pc<=0, cnt<=0, stay in RUN, no done; loop=0: normal DONE. loop is
//   sampled on the ending edge only.
//  Undefined: no loop port; program end always goes to DONE.
// STRUCTURE
//  op_seq_pkg: OP_NOP=2'b00, OP_1=2'b01, OP_2=2'b10, OP_3=2'b11; state enum {S_IDLE,S_RUN,S_DONE};
//   word field offsets/width function of REP_W; HALT_WORD constant.
//  Sub-module op_seq_prog_mem: DEPTH x (REP_W+3) flop array, async reset to HALT_WORD, registered
//   write, combinational read. FSM, pc and cnt stay in op_seq_issuer.
// TESTING (DEPTH=8, REP_W=2)
//  1 Reset: reset=1 mid-RUN -> op=00, busy=0, pc=0 same cycle; then start alone -> HALT, done after 2 cyc.
//  2 Load {01,0,01},{10,1,00},HALT; start -> op/dest seq 01/0,01/0,10/1,00/0, done pulse next cycle,
//    datapath R0/R1 match the hand-driven sequence.
//  3 Hold: same program, hold=1 on 2nd issue cycle -> extra 00 cycle, seq otherwise unchanged, pc frozen.
//  4 Full program: 8 words rep=11, no HALT -> exactly 32 issue cycles, done 1 cycle later, pc stops at 7.
//  5 Write in RUN to addr 1 -> ignored, readback via rerun unchanged; wr_en+start same cycle to addr 0
//    -> new word 0 issued first.
//  6 OP_SEQ_LOOP_EN, loop=1, 2-word program -> repeats with no done; drop loop -> done at next end.

Source files
------------

// File: rtl/op_seq_pkg.sv
// Shared types and word-format helpers for the op/dest sequence issuer.
// Word layout is {op[1:0], dest, rep[REP_W-1:0]}.
package op_seq_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_1   = 2'b01;
  localparam logic [1:0] OP_2   = 2'b10;
  localparam logic [1:0] OP_3   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic int word_w(input int rep_w);
    return rep_w + 3;
  endfunction

  function automatic int dest_bit(input int rep_w);
    return rep_w;
  endfunction

  function automatic int op_lsb(input int rep_w);
    return rep_w + 1;
  endfunction

  // HALT is op=NOP with dest=1; the rep field is ignored.
  function automatic logic [31:0] halt_word(input int rep_w);
    return 32'd1 << rep_w;
  endfunction

endpackage

// File: rtl/op_seq_if.sv
// Datapath-facing op/dest bus driven by the issuer.
// master drives the bus, slave is the register datapath.
interface op_seq_if;
  import op_seq_pkg::*;

  logic [1:0] op;
  logic       dest;

  modport master (output op, output dest);
  modport slave  (input  op, input  dest);

endinterface

// File: rtl/op_seq_prog_mem.sv
// Program store: flop array reset to HALT, registered write, async read.
// Writes are gated by the caller.
module op_seq_prog_mem
  import op_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int REP_W = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int WW    = REP_W + 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [WW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [WW-1:0] o_rdata
);

  localparam logic [WW-1:0] HALT = WW'(halt_word(REP_W));

  logic [WW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= HALT;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/op_seq_issuer.sv
// Runs a small loaded program onto the op/dest datapath bus.
// Define OP_SEQ_LOOP_EN to add the loop input (restart instead of done).
module op_seq_issuer
  import op_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int REP_W = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [REP_W+2:0]   wr_data,
  input  logic               start,
  input  logic               hold,
`ifdef OP_SEQ_LOOP_EN
  input  logic               loop,
`endif
  op_seq_if.master           dp,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      pc
);

  localparam int WW = word_w(REP_W);
  localparam int DB = dest_bit(REP_W);
  localparam int OL = op_lsb(REP_W);

  state_t           r_state;
  logic [AW-1:0]    r_pc;
  logic [REP_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WW-1:0]    w_word;
  logic [1:0]       w_op;
  logic             w_dest;
  logic [REP_W-1:0] w_rep;
  logic             w_halt;
  logic             w_hit;
  logic             w_end;
  logic             w_loop;

  op_seq_prog_mem #(
    .DEPTH (DEPTH),
    .REP_W (REP_W),
    .AW    (AW),
    .WW    (WW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (wr_en && !r_busy),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (r_pc),
    .o_rdata (w_word)
  );

  assign w_op   = w_word[OL+1:OL];
  assign w_dest = w_word[DB];
  assign w_rep  = w_word[REP_W-1:0];
  assign w_halt = (w_op == OP_NOP) && w_dest;
  assign w_hit  = (r_cnt == w_rep);
  assign w_end  = w_halt ||
                  (w_hit && r_pc == AW'(DEPTH - 1));

`ifdef OP_SEQ_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  // Bus follows state combinationally so an async reset silences it at once.
  always_comb begin
    dp.op   = OP_NOP;
    dp.dest = 1'b0;
    if (r_state == S_RUN && !hold && !w_halt) begin
      dp.op   = w_op;
      dp.dest = w_dest;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (w_end) begin
              r_cnt <= '0;
              if (w_loop) begin
                r_pc <= '0;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else if (w_hit) begin
              r_cnt <= '0;
              r_pc  <= r_pc + AW'(1);
            end else begin
              r_cnt <= r_cnt + REP_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign pc   = r_pc;

endmodule

// File: tb/tb_op_seq_issuer.sv
// Directed bench for op_seq_issuer (DEPTH=8, REP_W=2).
// Loop scenario runs only when OP_SEQ_LOOP_EN is defined.
module tb_op_seq_issuer;
  import op_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       start;
  logic       hold;
`ifdef OP_SEQ_LOOP_EN
  logic       loop;
`endif
  logic       busy;
  logic       done;
  logic [2:0] pc;

  op_seq_if dp ();

  op_seq_issuer #(
    .DEPTH (8),
    .REP_W (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .hold    (hold),
`ifdef OP_SEQ_LOOP_EN
    .loop    (loop),
`endif
    .dp      (dp.master),
    .busy    (busy),
    .done    (done),
    .pc      (pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q  [$];
  logic       hold_q [$];
  logic [2:0] pc_q   [$];

  localparam logic [4:0] HALT = 5'b00100;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] w(input logic [1:0] op,
                                   input logic dst,
                                   input logic [1:0] rep);
    return {op, dst, rep};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [4:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete();
    hold_q.delete();
    pc_q.delete();
  endtask

  task automatic run_check(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      hold = (i < hold_q.size()) ? hold_q[i] : 1'b0;
      #1;
      check($sformatf("%s opdest[%0d]", tag, i),
            {29'd0, dp.op, dp.dest}, {29'd0, exp_q[i]});
      check($sformatf("%s busy[%0d]", tag, i),
            {31'd0, busy}, 32'd1);
      if (i < pc_q.size())
        check($sformatf("%s pc[%0d]", tag, i),
              {29'd0, pc}, {29'd0, pc_q[i]});
      step();
    end
    hold = 1'b0;
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, " op_end"}, {29'd0, dp.op, dp.dest}, 32'd0);
    step();
    check({tag, " done_off"}, {31'd0, done}, 32'd0);
  endtask

  task automatic load_full();
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), w(2'((i % 3) + 1), i[0], 2'b11));
    end
  endtask

  task automatic full_q(input int from_word);
    for (int i = from_word; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({2'((i % 3) + 1), i[0]});
        pc_q.push_back(3'(i));
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    hold    = 1'b0;
`ifdef OP_SEQ_LOOP_EN
    loop    = 1'b0;
`endif
    #12;
    reset = 1'b0;
    check("rst op",   {29'd0, dp.op, dp.dest}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst pc",   {29'd0, pc}, 32'd0);
    step();

    // Basic three-word program
    wr(3'd0, w(OP_1, 1'b0, 2'b01));
    wr(3'd1, w(OP_2, 1'b1, 2'b00));
    wr(3'd2, HALT);
    clear_q();
    exp_q = '{3'b010, 3'b010, 3'b101, 3'b000};
    pc_q  = '{3'd0, 3'd0, 3'd1, 3'd2};
    start_run();
    run_check("basic");

    // Hold on the second issue cycle
    clear_q();
    exp_q  = '{3'b010, 3'b000, 3'b010, 3'b101, 3'b000};
    hold_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pc_q   = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
    start_run();
    run_check("hold");

    // Async reset mid-run, then memory must read back as HALT
    start_run();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("midrst op",   {29'd0, dp.op, dp.dest}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst pc",   {29'd0, pc}, 32'd0);
    #1;
    reset = 1'b0;
    step();
    clear_q();
    exp_q = '{3'b000};
    pc_q  = '{3'd0};
    start_run();
    run_check("afterrst");

    // Full program without HALT
    load_full();
    clear_q();
    full_q(0);
    start_run();
    run_check("full");
    check("full pc_stop", {29'd0, pc}, 32'd7);

    // Write during RUN is dropped
    start_run();
    #1;
    check("wrrun first", {29'd0, dp.op, dp.dest}, {29'd0, 3'b010});
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = w(OP_3, 1'b0, 2'b00);
    step();
    wr_en = 1'b0;
    clear_q();
    full_q(0);
    void'(exp_q.pop_front());
    void'(pc_q.pop_front());
    run_check("wrrun");
    clear_q();
    full_q(0);
    start_run();
    run_check("rerun");

    // Write and start in the same IDLE cycle
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = w(OP_3, 1'b0, 2'b00);
    start   = 1'b1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    clear_q();
    exp_q.push_back(3'b110);
    pc_q.push_back(3'd0);
    full_q(1);
    run_check("wrstart");

`ifdef OP_SEQ_LOOP_EN
    wr(3'd0, w(OP_1, 1'b0, 2'b00));
    wr(3'd1, w(OP_2, 1'b1, 2'b00));
    wr(3'd2, HALT);
    loop = 1'b1;
    start_run();
    for (int r = 0; r < 2; r++) begin
      clear_q();
      exp_q = '{3'b010, 3'b101, 3'b000};
      for (int i = 0; i < 3; i++) begin
        #1;
        check($sformatf("loop opdest[%0d,%0d]", r, i),
              {29'd0, dp.op, dp.dest}, {29'd0, exp_q[i]});
        check($sformatf("loop done[%0d,%0d]", r, i),
              {31'd0, done}, 32'd0);
        step();
      end
    end
    loop = 1'b0;
    clear_q();
    exp_q = '{3'b010, 3'b101, 3'b000};
    run_check("loopend");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
